// File: rtl/seq_pkg.sv
// Shared types for the program-counter sequencer: op codes, FSM states, error codes.
package seq_pkg;

    typedef enum logic [2:0] {
        OP_SEQ  = 3'd0,
        OP_RELJ = 3'd1,
        OP_ABSJ = 3'd2,
        OP_BRC  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_HALT = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT,
        ST_ERR
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-side bundle of the sequencer: op/flag/LUT-write inputs and PC/status outputs.
interface pc_sequencer_if #(
    parameter int D  = 12,
    parameter int LA = 4,
    parameter int SD = 4
);
    localparam int SPW = $clog2(SD + 1);

    logic          start;
    logic          stall;
    logic [2:0]    op;
    logic [D-1:0]  rel_off;
    logic [LA-1:0] lut_idx;
    logic          lut_wr_en;
    logic [LA-1:0] lut_wr_idx;
    logic [D-1:0]  lut_wr_data;
    logic          flag_d;
    logic          flag_en;

    logic [D-1:0]   prog_ctr;
    logic           flag_q;
    logic [SPW-1:0] sp;
    logic           running;
    logic           done;
    logic [1:0]     err;

    modport master (
        output start, stall, op, rel_off, lut_idx, lut_wr_en, lut_wr_idx, lut_wr_data,
               flag_d, flag_en,
        input  prog_ctr, flag_q, sp, running, done, err
    );

    modport slave (
        input  start, stall, op, rel_off, lut_idx, lut_wr_en, lut_wr_idx, lut_wr_data,
               flag_d, flag_en,
        output prog_ctr, flag_q, sp, running, done, err
    );

endinterface

// File: rtl/seq_stack.sv
// Return-address LIFO; push-when-full and pop-when-empty are silently dropped.
module seq_stack #(
    parameter int D   = 12,
    parameter int SD  = 4,
    parameter int SPW = $clog2(SD + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           push,
    input  logic           pop,
    input  logic [D-1:0]   din,
    output logic [D-1:0]   dout,
    output logic [SPW-1:0] sp,
    output logic           full,
    output logic           empty
);
    localparam int AW = (SD > 1) ? $clog2(SD) : 1;

    logic [D-1:0]   mem [SD];
    logic [SPW-1:0] cnt;
    logic [SPW-1:0] top;

    assign full  = (cnt == SPW'(SD));
    assign empty = (cnt == '0);
    assign top   = cnt - SPW'(1);
    assign dout  = mem[top[AW-1:0]];
    assign sp    = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            for (int i = 0; i < SD; i++) mem[i] <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (push && !full) begin
            mem[cnt[AW-1:0]] <= din;
            cnt              <= cnt + SPW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - SPW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: PC, branch-target LUT, lagging condition flag and call stack,
// with start/stall/done handshake and sticky overflow/underflow errors.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int          D         = 12,
    parameter int          LA        = 4,
    parameter int          SD        = 4,
    parameter int unsigned DONE_ADDR = 9
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int          SPW     = $clog2(SD + 1);
    localparam logic [D-1:0] DONE_PC = D'(DONE_ADDR);

    state_e       state_q, state_n;
    logic [D-1:0] pc_q, pc_n;
    logic         flag_q, flag_n;
    logic [1:0]   err_q, err_n;

    logic [D-1:0] lut [2**LA];
    logic [D-1:0] tgt, inc, nxt;
    logic         fault, halt_op;

    logic           push, pop, clr;
    logic [D-1:0]   stk_dout;
    logic [SPW-1:0] stk_sp;
    logic           stk_full, stk_empty;

    seq_stack #(.D(D), .SD(SD), .SPW(SPW)) u_stack (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .din   (inc),
        .dout  (stk_dout),
        .sp    (stk_sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign tgt = lut[bus.lut_idx];
    assign inc = pc_q + D'(1);

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        flag_n  = flag_q;
        err_n   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        nxt     = inc;
        fault   = 1'b0;
        halt_op = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!bus.stall) begin
                    // Branch decisions read the old flag_q; the new capture lands after.
                    if (bus.flag_en) flag_n = bus.flag_d;
                    case (bus.op)
                        OP_RELJ: nxt = pc_q + bus.rel_off;
                        OP_ABSJ: nxt = tgt;
                        OP_BRC:  if (flag_q) nxt = tgt;
                        OP_CALL: begin
                            if (stk_full) begin
                                fault = 1'b1;
                                err_n = ERR_OVF;
                            end else begin
                                push = 1'b1;
                                nxt  = tgt;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                fault = 1'b1;
                                err_n = ERR_UNF;
                            end else begin
                                pop = 1'b1;
                                nxt = stk_dout;
                            end
                        end
                        OP_HALT: halt_op = 1'b1;
                        default: nxt = inc;
                    endcase
                    if (fault) begin
                        state_n = ST_ERR;
                    end else if (halt_op) begin
                        state_n = ST_HALT;
                    end else begin
                        pc_n = nxt;
                        if (nxt == DONE_PC) state_n = ST_HALT;
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    state_n = ST_RUN;
                    pc_n    = '0;
                    flag_n  = 1'b0;
                    err_n   = ERR_NONE;
                    clr     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            flag_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            flag_q  <= flag_n;
            err_q   <= err_n;
        end
    end

    // Written in every state, stall included; same-cycle reads see the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2**LA; i++) lut[i] <= '0;
        end else if (bus.lut_wr_en) begin
            lut[bus.lut_wr_idx] <= bus.lut_wr_data;
        end
    end

    assign bus.prog_ctr = pc_q;
    assign bus.flag_q   = flag_q;
    assign bus.sp       = stk_sp;
    assign bus.running  = (state_q == ST_RUN);
    assign bus.done     = (state_q == ST_HALT) || (state_q == ST_ERR);
    assign bus.err      = err_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the single-cycle fetch path: program counter, loadable branch-target LUT, lagging condition flag, and call/return stack in one sequencer.
Adds start/stall/done handshaking and sticky error reporting, which the fixed-width PC/PC_LUT pair lacks.
Sits between instr_ROM (drives its prog_ctr) and the Control decoder, which supplies the op code and the flag source.

Parameters:
D, 12, program counter width (bits)
LA, 4, branch LUT index width; LUT holds 2**LA entries of D bits
SD, 4, call stack depth (entries); SD >= 1
DONE_ADDR, 9, PC value that terminates the program

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request: start or restart the program
stall  input  1  hold PC, flag and stack for this cycle
op  input  3  sequencer op: 0 SEQ, 1 RELJ, 2 ABSJ, 3 BRC, 4 CALL, 5 RET, 6 HALT, 7 reserved (treated as SEQ)
rel_off  input  D  signed two's-complement offset for RELJ
lut_idx  input  LA  LUT index for ABSJ/BRC/CALL
lut_wr_en  input  1  LUT write strobe
lut_wr_idx  input  LA  LUT write index
lut_wr_data  input  D  LUT write data
flag_d  input  1  condition from ALU ("one" result)
flag_en  input  1  capture flag_d this cycle
prog_ctr  output  D  current PC
flag_q  output  1  lagging condition flag
sp  output  $clog2(SD+1)  stack occupancy
running  output  1  high in RUN
done  output  1  high in HALT or ERR
err  output  2  0 none, 1 stack overflow, 2 stack underflow

Behaviour:
- Reset (asynchronous, while low): prog_ctr=0, flag_q=0, sp=0, all LUT entries 0, err=0, state IDLE. Outputs then: running=0, done=0.
- States: IDLE, RUN, HALT, ERR. running = (state==RUN). done = (state==HALT or ERR).
- IDLE: PC holds 0; op/stall ignored. start=1 -> RUN next edge; the first RUN cycle presents PC=0.
- RUN, stall=0, next PC per op (all arithmetic modulo 2**D, wrap silently):
  - SEQ: PC+1
  - RELJ: PC+rel_off (sign-extended)
  - ABSJ: lut[lut_idx]
  - BRC: lut[lut_idx] if flag_q=1, else PC+1
  - CALL: push PC+1, PC <= lut[lut_idx]
  - RET: pop, PC <= popped value
  - HALT: PC holds -> HALT
- Stack: CALL with sp==SD -> ERR, err=1, PC and stack unchanged. RET with sp==0 -> ERR, err=2, PC unchanged.
- DONE_ADDR: if the computed next PC equals DONE_ADDR, PC loads it and state -> HALT on the same edge. done is high while prog_ctr shows DONE_ADDR.
- Flag: flag_q <= flag_d when RUN, flag_en=1 and stall=0. BRC therefore tests the flag captured by an earlier instruction (one-cycle lag). flag_en on the same cycle as BRC: the branch uses the old flag_q; the new value lands afterwards.
- stall=1 in RUN: PC, flag_q, sp, stack and state all hold; op ignored.
- LUT write: any state, including during stall, synchronous on the edge. A read of the same index in the same cycle returns the old value.
- HALT/ERR: sticky; PC holds. start=1 -> RUN next edge with PC=0, sp=0, flag_q=0, err=0; LUT contents retained.
- start in RUN: ignored.
- Reset mid-operation: immediate return to reset values regardless of state; LUT cleared.

Decomposition:
- Shared package seq_pkg: op enum (SEQ..HALT), state enum, err code constants.
- One sub-module: seq_stack (parametrised LIFO, D wide, SD deep). Ports: push, pop, din, dout, sp, full, empty. Pushing when full and popping when empty are blocked internally.
- The LUT stays inline as a register array.

Test Plan:
- Reset, start, 5x SEQ -> prog_ctr 0,1,2,3,4,5; running=1, done=0, sp=0.
- Write lut[3]=0x040, then ABSJ idx 3 -> PC=0x040. RELJ rel_off=0xFFE (-2) -> 0x03E. Then with PC=0xFFF, SEQ -> 0x000 (wrap).
- BRC branch path: flag_en=1, flag_d=1 on one cycle; BRC idx 3 on the next -> PC=0x040. BRC path not taken: flag_d=0 captured -> PC+1. Same-cycle flag_en plus BRC -> uses the old flag.
- CALL x4 (SD=4) to lut[1]=0x100 from PCs 0x010,0x100,0x100,0x100 -> sp=4. A fifth CALL -> err=1, done=1, PC holds. Restart, CALL then RET -> returns to 0x011. RET at sp=0 -> err=2.
- SEQ from PC=8 -> PC=9 with done=1 on that edge; stall is ignored thereafter. start -> PC=0, running=1, LUT values intact.
- stall high for 3 cycles mid-RUN with CALL on op -> PC, sp and flag_q unchanged, and a LUT write during the stall takes effect. Assert reset mid-CALL -> PC=0, sp=0, IDLE asynchronously.
